// File: rtl/hop_seq_ctrl_if.sv
// hop_seq_ctrl_if: control/status bundle between the tag controller and the hop sequencer.
interface hop_seq_ctrl_if #(
   parameter int PHASE_WIDTH   = 24,
   parameter int HOP_CNT_WIDTH = 8
);
   logic                     start;
   logic                     abort;
   logic                     hop_done;
   logic                     busy;
   logic                     sync_active;
   logic                     tx_en;
   logic                     hop_rst;
   logic                     frame_done;
   logic [HOP_CNT_WIDTH-1:0] hop_n;
   logic [PHASE_WIDTH-1:0]   hop_phase_inc;
   logic [1:0]               state;
   modport master (
      output start, abort, hop_done,
      input  busy, sync_active, tx_en, hop_rst, frame_done, hop_n, hop_phase_inc, state
   );
   modport slave (
      input  start, abort, hop_done,
      output busy, sync_active, tx_en, hop_rst, frame_done, hop_n, hop_phase_inc, state
   );
endinterface

// File: rtl/hop_seq_ctrl.sv
// hop_seq_ctrl: frame sequencer (local sync, then NUM_HOPS x {hop sync, transmit}) with phase plan.
module hop_seq_ctrl #(
   parameter int          PHASE_WIDTH    = 24,
   parameter int          SYNC_CNT_WIDTH = 16,
   parameter int          HOP_CNT_WIDTH  = 8,
   parameter int          NUM_HOPS       = 64,
   parameter int          LOC_SYNC_N     = 16384,
   parameter int          HOP_SYNC_N     = 16384,
   parameter int unsigned START_PH_INC   = 8192,
   parameter int unsigned HOP_DPH_INC    = 131072,
   parameter bit          CONTINUOUS     = 1'b0
) (
   input logic           clk,
   input logic           reset,
   hop_seq_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'b00, LOC_SYNC = 2'b01, HOP_SYNC = 2'b10, HOP_TX = 2'b11} state_t;
   localparam logic [SYNC_CNT_WIDTH-1:0] LOC_LOAD = SYNC_CNT_WIDTH'(LOC_SYNC_N - 1);
   localparam logic [SYNC_CNT_WIDTH-1:0] HOP_LOAD = SYNC_CNT_WIDTH'(HOP_SYNC_N - 1);
   localparam logic [HOP_CNT_WIDTH-1:0]  LAST_HOP = HOP_CNT_WIDTH'(NUM_HOPS - 1);
   localparam logic [PHASE_WIDTH-1:0]    PH0      = PHASE_WIDTH'(START_PH_INC);
   localparam logic [PHASE_WIDTH-1:0]    DPH      = PHASE_WIDTH'(HOP_DPH_INC);
   state_t                    st, st_d;
   logic [SYNC_CNT_WIDTH-1:0] sync_cnt, sync_cnt_d;
   logic [HOP_CNT_WIDTH-1:0]  hop_n, hop_n_d;
   logic [PHASE_WIDTH-1:0]    ph, ph_d;
   logic                      hop_rst, hop_rst_d, frame_done, frame_done_d;
   always_ff @(posedge clk) begin
      if (reset) begin
         st         <= IDLE;
         sync_cnt   <= '0;
         hop_n      <= '0;
         ph         <= PH0;
         hop_rst    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         st         <= st_d;
         sync_cnt   <= sync_cnt_d;
         hop_n      <= hop_n_d;
         ph         <= ph_d;
         hop_rst    <= hop_rst_d;
         frame_done <= frame_done_d;
      end
   end
   // abort outranks every in-frame transition, including a coincident hop_done
   always_comb begin
      st_d         = st;
      sync_cnt_d   = sync_cnt;
      hop_n_d      = hop_n;
      ph_d         = ph;
      hop_rst_d    = 1'b0;
      frame_done_d = 1'b0;
      if (st == IDLE) begin
         hop_n_d    = '0;
         ph_d       = PH0;
         sync_cnt_d = LOC_LOAD;
         st_d       = (bus.start || CONTINUOUS) ? LOC_SYNC : IDLE;
      end else if (bus.abort) begin
         st_d       = IDLE;
         hop_n_d    = '0;
         ph_d       = PH0;
         sync_cnt_d = '0;
      end else if (st != HOP_TX) begin
         sync_cnt_d = (sync_cnt == '0) ? HOP_LOAD : sync_cnt - SYNC_CNT_WIDTH'(1);
         st_d       = (sync_cnt != '0) ? st : (st == LOC_SYNC) ? HOP_SYNC : HOP_TX;
         hop_rst_d  = (sync_cnt == '0) && (st == LOC_SYNC);
      end else if (bus.hop_done) begin
         if (hop_n < LAST_HOP) begin
            st_d       = HOP_SYNC;
            hop_n_d    = hop_n + HOP_CNT_WIDTH'(1);
            ph_d       = ph + DPH;
            sync_cnt_d = HOP_LOAD;
            hop_rst_d  = 1'b1;
         end else begin
            st_d         = IDLE;
            frame_done_d = 1'b1;
         end
      end
   end
   assign bus.busy          = st != IDLE;
   assign bus.sync_active   = (st == LOC_SYNC) || (st == HOP_SYNC);
   assign bus.tx_en         = st == HOP_TX;
   assign bus.hop_rst       = hop_rst;
   assign bus.frame_done    = frame_done;
   assign bus.hop_n         = hop_n;
   assign bus.hop_phase_inc = ph;
   assign bus.state         = st;
endmodule
